// File: rtl/cache_controller.sv
// cache_controller
// 2-way set-associative, write-through, no-write-allocate data cache. It sits
// between the MEM stage and the SRAM controller. One line holds one 32-bit word.
// Read hits complete in the same cycle. Read misses and all writes are forwarded
// to the SRAM controller, so the MEM stage sees a single rdEn/wrEn/ready interface.
//
// Handshake (both sides): a request (rdEn/wrEn, or sramRdEn/sramWrEn) is held
// high until the matching ready is sampled high on a rising edge. That cycle
// completes the transfer. Read data is valid only in the cycle where ready=1.
// The SRAM controller holds sramReady high while idle. That level is ignored
// here until a forwarded request is active.
//
// Ports:
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   rdEn, wrEn        MEM-stage read/write requests (wrEn wins)
//   address           MEM-stage word-aligned byte address (>= BASE_ADDR)
//   writeData         MEM-stage store data
//   readData, ready   load data and completion / no-stall flag
//   sramRdEn/WrEn     forwarded requests to the SRAM controller
//   sramAddress       byte address to SRAM (the controller subtracts its base)
//   sramWriteData     store data to SRAM
//   sramReadData      SRAM read data
//   sramReady         SRAM completion
//   o_dbg_state       current FSM state (0 IDLE, 1 READ_MISS, 2 WRITE_THRU)
module cache_controller #(
  parameter int SET_COUNT = 64,
  parameter int INDEX_W   = 6,
  parameter int TAG_W     = 11,
  parameter int BASE_ADDR = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdEn,
  input  logic        wrEn,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        sramRdEn,
  output logic        sramWrEn,
  output logic [31:0] sramAddress,
  output logic [31:0] sramWriteData,
  input  logic [31:0] sramReadData,
  input  logic        sramReady,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_READ_MISS  = 2'd1,
    S_WRITE_THRU = 2'd2
  } state_t;

  state_t r_state, w_next;
  logic [31:0] r_req_addr, r_req_data;

  logic [SET_COUNT-1:0] r_valid0, r_valid1, r_lru;  // r_lru=1: way1 is LRU
  logic [TAG_W-1:0]     r_tag0  [SET_COUNT];
  logic [TAG_W-1:0]     r_tag1  [SET_COUNT];
  logic [31:0]          r_data0 [SET_COUNT];
  logic [31:0]          r_data1 [SET_COUNT];

  // In IDLE, look up the live address so that hits cost zero cycles. After a
  // request is accepted, all processing uses the latched request address.
  logic [31:0]        w_lookup_addr;
  logic [16:0]        w_word;
  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit0, w_hit1, w_hit;
  logic               w_fill_way, w_fill, w_wr_upd, w_rd_hit_upd;
  logic               w_lru_upd, w_lru_new;

  assign w_lookup_addr = (r_state == S_IDLE) ? address : r_req_addr;
  assign w_word        = 17'((w_lookup_addr - 32'(BASE_ADDR)) >> 2);
  assign w_index       = w_word[INDEX_W-1:0];
  assign w_tag         = w_word[16:INDEX_W];

  assign w_hit0 = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
  assign w_hit1 = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;

  // Fill the first invalid way (way0 first). If both ways are valid, evict the LRU way.
  assign w_fill_way = !r_valid0[w_index] ? 1'b0 :
                      !r_valid1[w_index] ? 1'b1 : r_lru[w_index];

  assign w_rd_hit_upd = (r_state == S_IDLE) && rdEn && !wrEn && w_hit;
  assign w_fill       = (r_state == S_READ_MISS) && sramReady;
  assign w_wr_upd     = (r_state == S_WRITE_THRU) && sramReady && w_hit;
  assign w_lru_upd    = w_rd_hit_upd | w_fill | w_wr_upd;
  // The LRU bit points at the way that was not just touched.
  assign w_lru_new    = w_fill ? ~w_fill_way : w_hit0;

  assign sramAddress   = r_req_addr;
  assign sramWriteData = r_req_data;
  assign o_dbg_state   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req_addr <= '0;
      r_req_data <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && (rdEn || wrEn)) begin
        r_req_addr <= address;
        r_req_data <= writeData;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid0 <= '0;
      r_valid1 <= '0;
      r_lru    <= '0;
    end else begin
      if (w_lru_upd) r_lru[w_index] <= w_lru_new;
      if (w_fill) begin
        if (w_fill_way) r_valid1[w_index] <= 1'b1;
        else            r_valid0[w_index] <= 1'b1;
      end
    end
  end

  // Tags and data need no reset; an entry is meaningful only while its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      if (w_fill_way) begin
        r_tag1[w_index]  <= w_tag;
        r_data1[w_index] <= sramReadData;
      end else begin
        r_tag0[w_index]  <= w_tag;
        r_data0[w_index] <= sramReadData;
      end
    end else if (w_wr_upd) begin
      if (w_hit1) r_data1[w_index] <= r_req_data;
      else        r_data0[w_index] <= r_req_data;
    end
  end

  always_comb begin
    w_next   = r_state;
    ready    = 1'b0;
    readData = '0;
    sramRdEn = 1'b0;
    sramWrEn = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wrEn) begin
          w_next = S_WRITE_THRU;
        end else if (rdEn) begin
          if (w_hit) begin
            ready    = 1'b1;
            readData = w_hit1 ? r_data1[w_index] : r_data0[w_index];
          end else begin
            w_next = S_READ_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      S_READ_MISS: begin
        sramRdEn = 1'b1;
        if (sramReady) begin
          ready    = 1'b1;
          readData = sramReadData;
          w_next   = S_IDLE;
        end
      end
      S_WRITE_THRU: begin
        sramWrEn = 1'b1;
        if (sramReady) begin
          ready  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdEn = 1'b0, wrEn = 1'b0;
  logic [31:0] address = '0, writeData = '0;
  logic [31:0] readData;
  logic        ready;
  logic        sramRdEn, sramWrEn;
  logic [31:0] sramAddress, sramWriteData;
  logic [31:0] sramReadData = '0;
  logic        sramReady = 1'b1;
  logic [1:0]  o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cur_id = -1;

  cache_controller dut (
    .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn), .address(address),
    .writeData(writeData), .readData(readData), .ready(ready),
    .sramRdEn(sramRdEn), .sramWrEn(sramWrEn), .sramAddress(sramAddress),
    .sramWriteData(sramWriteData), .sramReadData(sramReadData),
    .sramReady(sramReady), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;        // SRAM wait cycles before sramReady
    logic        hit;        // expect a same-cycle read hit
    logic [31:0] sram_data;  // what the SRAM returns on a read
    logic [31:0] exp_rdata;  // expected readData on completion
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd, input int lat, input logic hit,
                     input logic [31:0] sd, input logic [31:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.lat = lat;
    v.hit = hit; v.sram_data = sd; v.exp_rdata = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d) @%0t: got %h want %h", name, cur_id, $time, act, exp);
    end
  endtask

  // driver: applies one request and acts as the SRAM controller
  task automatic run_vec(input vec_t v);
    logic exp_rd, exp_wr;
    exp_rd = v.rd && !v.wr && !v.hit;
    exp_wr = v.wr;
    @(posedge clk); #1;
    rdEn = v.rd; wrEn = v.wr; address = v.addr; writeData = v.wdata;
    sramReady = 1'b1;  // idle-level ready must not complete anything in IDLE
    sramReadData = 32'h0BAD0BAD;
    @(negedge clk);
    if (v.hit) begin
      check("hit_ready", 32'(ready), 32'd1);
      check("hit_rdata", readData, v.exp_rdata);
      check("hit_no_sram", {30'd0, sramRdEn, sramWrEn}, 32'd0);
    end else begin
      check("accept_stall", 32'(ready), 32'd0);
      check("accept_no_sram", {30'd0, sramRdEn, sramWrEn}, 32'd0);
      @(posedge clk); #1;
      sramReady = 1'b0;
      for (int c = 0; c < v.lat; c++) begin
        @(negedge clk);
        check("wait_ready", 32'(ready), 32'd0);
        check("wait_sram_en", {30'd0, sramRdEn, sramWrEn}, {30'd0, exp_rd, exp_wr});
        check("wait_sram_addr", sramAddress, v.addr);
        if (exp_wr) check("wait_sram_wdata", sramWriteData, v.wdata);
        @(posedge clk); #1;
      end
      sramReady = 1'b1;
      sramReadData = v.sram_data;
      @(negedge clk);
      check("done_ready", 32'(ready), 32'd1);
      check("done_sram_en", {30'd0, sramRdEn, sramWrEn}, {30'd0, exp_rd, exp_wr});
      check("done_sram_addr", sramAddress, v.addr);
      if (exp_rd) check("done_rdata", readData, v.exp_rdata);
      if (exp_wr) check("done_sram_wdata", sramWriteData, v.wdata);
    end
    @(posedge clk); #1;
    rdEn = 1'b0; wrEn = 1'b0;
    @(negedge clk);
    check("after_idle", {28'd0, o_dbg_state, sramRdEn, sramWrEn}, 32'd0);
    check("after_ready", 32'(ready), 32'd1);
    check("after_rdata", readData, 32'd0);
  endtask

  initial begin
    // Index 0 holds 1024 (tag 0), 1280 (tag 1), 1536 (tag 2), 2048 (tag 4)
    //           rd wr addr  wdata          lat hit sram_data      exp_rdata
    add(1, 0, 1024, 0,             2, 0, 32'hDEADBEEF, 32'hDEADBEEF); // 0 miss -> way0
    add(1, 0, 1024, 0,             0, 1, 0,            32'hDEADBEEF); // 1 hit
    add(0, 1, 1024, 32'h12345678,  1, 0, 0,            0);            // 2 write hit
    add(1, 0, 1024, 0,             0, 1, 0,            32'h12345678); // 3 hit new data
    add(1, 0, 1280, 0,             3, 0, 32'hAAAA1280, 32'hAAAA1280); // 4 miss -> way1
    add(1, 0, 1024, 0,             0, 1, 0,            32'h12345678); // 5 hit, way1 LRU
    add(1, 0, 1536, 0,             0, 0, 32'hBBBB1536, 32'hBBBB1536); // 6 miss evicts 1280
    add(1, 0, 1536, 0,             0, 1, 0,            32'hBBBB1536); // 7 hit
    add(1, 0, 1024, 0,             0, 1, 0,            32'h12345678); // 8 hit, way1 LRU
    add(1, 0, 1280, 0,             1, 0, 32'hAAAA1280, 32'hAAAA1280); // 9 miss (evicted)
    add(0, 1, 2048, 32'h55AA55AA,  2, 0, 0,            0);            // 10 write miss
    add(1, 0, 2048, 0,             1, 0, 32'h55AA55AA, 32'h55AA55AA); // 11 read misses: no allocate
    add(1, 0, 1280, 0,             0, 1, 0,            32'hAAAA1280); // 12 hit way1
    add(1, 0, 1024, 0,             0, 0, 32'h12345678, 32'h12345678); // 13 miss (evicted by 2048)
    add(1, 1, 1024, 32'hCAFEF00D,  1, 0, 0,            0);            // 14 rd+wr: write wins
    add(1, 0, 1024, 0,             0, 1, 0,            32'hCAFEF00D); // 15 hit written data
    add(1, 0, 1028, 0,             1, 0, 32'h11112222, 32'h11112222); // 16 index 1 miss
    add(1, 0, 1028, 0,             0, 1, 0,            32'h11112222); // 17 index 1 hit
    add(1, 0, 1276, 0,             2, 0, 32'h63636363, 32'h63636363); // 18 index 63 miss
    add(1, 0, 1276, 0,             0, 1, 0,            32'h63636363); // 19 index 63 hit

    // reset state
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rdata", readData, 32'd0);
    check("rst_sram_en", {30'd0, sramRdEn, sramWrEn}, 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cur_id = i;
      run_vec(vecs[i]);
    end

    // read held high after completion re-hits with no SRAM traffic
    cur_id = 100;
    @(posedge clk); #1;
    rdEn = 1'b1; address = 1024;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("held_ready", 32'(ready), 32'd1);
      check("held_rdata", readData, 32'hCAFEF00D);
      check("held_no_sram", {30'd0, sramRdEn, sramWrEn}, 32'd0);
      @(posedge clk); #1;
    end
    rdEn = 1'b0;

    // reset during READ_MISS abandons the request
    cur_id = 200;
    @(posedge clk); #1;
    rdEn = 1'b1; address = 4096; sramReady = 1'b1;
    @(negedge clk);
    check("rm_accept_stall", 32'(ready), 32'd0);
    @(posedge clk); #1;
    sramReady = 1'b0;
    @(negedge clk);
    check("rm_sram_rd", {30'd0, sramRdEn, sramWrEn}, 32'd2);
    check("rm_state", 32'(o_dbg_state), 32'd1);
    #2;
    rst = 1'b1; rdEn = 1'b0;
    #1;
    check("rm_rst_sram_en", {30'd0, sramRdEn, sramWrEn}, 32'd0);
    check("rm_rst_state", 32'(o_dbg_state), 32'd0);
    check("rm_rst_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // reset invalidated everything: previously cached lines now miss
    vecs.delete();
    add(1, 0, 4096, 0, 1, 0, 32'h44440000, 32'h44440000);
    add(1, 0, 1024, 0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D);
    add(1, 0, 1024, 0, 0, 1, 0,            32'hCAFEF00D);
    for (int i = 0; i < vecs.size(); i++) begin
      cur_id = 300 + i;
      run_vec(vecs[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
